// File: rtl/proc_mc_pkg.sv
// Shared opcodes, ALU function codes and FSM state encoding for the
// multi-cycle core.
package proc_mc_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED,
    S_ERR
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_HALT, OP_NOP, OP_J, OP_ADDI, OP_SUBI,
      OP_BEQZ, OP_BNEZ, OP_RTYPE: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_rd(input logic [4:0] op);
    op_writes_rd = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/proc_mc_regfile.sv
// 8-entry general register file: two combinational read ports, one
// clocked write port, all entries cleared by reset.
module proc_mc_regfile
  import proc_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wdata;
    end
  end

  assign rdata_a = regs[ra_a];
  assign rdata_b = regs[ra_b];

endmodule

// File: rtl/proc_multicycle.sv
// Multi-cycle 16-bit-ISA core: FETCH/DECODE/EXEC/WB with a wait-state fetch
// handshake. Define PROC_MC_PERF_CNT_EN to build the cycle/instret counters.
module proc_multicycle
  import proc_mc_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 IMEM_AW  = 16,
  parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               imem_rdy,
  output logic               retire,
  output logic [IMEM_AW-1:0] pc_dbg,
  output logic               halted,
  output logic               err,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_instret
);

  localparam logic [IMEM_AW-1:0] PC_INIT = {RESET_PC[IMEM_AW-1:1], 1'b0};

  state_t            state_reg;
  logic [IMEM_AW-1:0] pc_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] alu_reg;
  logic              taken_reg;
  logic              retire_reg;
  logic              halted_reg;
  logic              err_reg;

  logic [4:0]        opcode;
  logic [1:0]        fn;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm5_sext;
  logic [IMEM_AW-1:0] pc_plus2;
  logic [IMEM_AW-1:0] br_off;
  logic [IMEM_AW-1:0] j_off;
  logic [DATA_W-1:0] alu_next;
  logic              taken_next;
  logic [IMEM_AW-1:0] target_next;
  logic [IMEM_AW-1:0] pc_next;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;

  assign opcode    = ir_reg[15:11];
  assign fn        = ir_reg[1:0];
  assign imm5_sext = DATA_W'(signed'(ir_reg[4:0]));
  assign pc_plus2  = pc_reg + IMEM_AW'(2);
  assign br_off    = IMEM_AW'(signed'(ir_reg[7:0]));
  assign j_off     = IMEM_AW'(signed'(ir_reg[10:0]));

  proc_mc_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_a    (ir_reg[10:8]),
    .ra_b    (ir_reg[7:5]),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (rf_we),
    .wa      (rf_wa),
    .wdata   (alu_reg)
  );

  // R-type names its destination in IR[4:2]; immediates reuse the rt field.
  assign rf_we = (state_reg == S_WB) && op_writes_rd(opcode);
  assign rf_wa = (opcode == OP_RTYPE) ? ir_reg[4:2] : ir_reg[7:5];

  always_comb begin
    alu_next   = '0;
    taken_next = 1'b0;
    case (opcode)
      OP_ADDI:  alu_next = a_reg + imm5_sext;
      OP_SUBI:  alu_next = imm5_sext - a_reg;
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  alu_next = a_reg + b_reg;
          FN_SUB:  alu_next = b_reg - a_reg;
          FN_XOR:  alu_next = a_reg ^ b_reg;
          default: alu_next = a_reg & ~b_reg;
        endcase
      end
      OP_BEQZ:  taken_next = (a_reg == '0);
      OP_BNEZ:  taken_next = (a_reg != '0);
      OP_J:     taken_next = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    target_next    = pc_plus2 + ((opcode == OP_J) ? j_off : br_off);
    target_next[0] = 1'b0;
    pc_next        = taken_reg ? target_next : pc_plus2;
    pc_next[0]     = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_FETCH;
      pc_reg     <= PC_INIT;
      ir_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      alu_reg    <= '0;
      taken_reg  <= 1'b0;
      retire_reg <= 1'b0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (imem_rdy) begin
            ir_reg    <= imem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg <= rs_data;
          b_reg <= rt_data;
          if (!op_legal(opcode)) begin
            err_reg   <= 1'b1;
            state_reg <= S_ERR;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_reg    <= alu_next;
          taken_reg  <= taken_next;
          retire_reg <= 1'b1;
          state_reg  <= S_WB;
        end
        S_WB: begin
          pc_reg <= pc_next;
          if (opcode == OP_HALT) begin
            halted_reg <= 1'b1;
            state_reg  <= S_HALTED;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Request is gated by rst so an in-flight fetch drops without waiting for a clock.
  assign imem_req  = (state_reg == S_FETCH) && !rst;
  assign imem_addr = pc_reg;
  assign pc_dbg    = pc_reg;
  assign retire    = retire_reg;
  assign halted    = halted_reg;
  assign err       = err_reg;

`ifdef PROC_MC_PERF_CNT_EN
  logic [31:0] cycles_reg;
  logic [31:0] instret_reg;
  logic        running;

  assign running = (state_reg != S_HALTED) && (state_reg != S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_reg  <= '0;
      instret_reg <= '0;
    end else begin
      if (running) begin
        cycles_reg <= cycles_reg + 32'd1;
      end
      if (retire_reg) begin
        instret_reg <= instret_reg + 32'd1;
      end
    end
  end

  assign perf_cycles  = cycles_reg;
  assign perf_instret = instret_reg;
`else
  assign perf_cycles  = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: doc/proc_multicycle.md
Name: proc_multicycle

Overview:
- Multi-cycle successor to the single-cycle 16-bit teaching core. Each instruction takes its own FETCH/DECODE/EXEC/WB states.
- Data width is parametrised, the instruction set is extended, and instruction fetch uses a wait-state memory handshake.
- Top-level processor block; instantiated by the system bench with an external instruction memory model.

Parameters:
- DATA_W, 16: register and ALU width; must be >= 16.
- IMEM_AW, 16: instruction address width. PC is byte-addressed and always even.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_rdy
- imem_addr  out  IMEM_AW  fetch address (= PC)
- imem_rdata  in  16  instruction word; valid when imem_rdy=1
- imem_rdy  in  1  memory accepts request and returns data this cycle
- retire  out  1  one-cycle pulse in the WB cycle of every instruction
- pc_dbg  out  IMEM_AW  current PC
- halted  out  1  sticky; set after HALT retires
- err  out  1  sticky; set on illegal opcode
- perf_cycles  out  32  cycle counter (optional feature)
- perf_instret  out  32  retired-instruction counter (optional feature)

Behaviour:
- Reset values (async, immediate): state=FETCH, PC=RESET_PC, imem_req=0, retire=0, halted=0, err=0, all 8 registers=0, perf counters=0.
- imem_req rises in the first FETCH cycle after reset release.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - When imem_rdy=1, latch imem_rdata into IR and go to DECODE.
  - Otherwise stay in FETCH; imem_addr stays stable.
- DECODE:
  - Latch rs=IR[10:8], rt=IR[7:5] operands into A/B.
  - Opcode IR[15:11] is checked here. Illegal opcode: err<=1, go to ERR.
- EXEC: ALU result and branch decision are registered.
- WB:
  - Writes rd when required; updates PC.
  - Pulses retire; returns to FETCH.
  - HALT goes to HALTED instead of FETCH.
- HALTED/ERR: terminal states. imem_req=0, PC frozen; exit only via rst.
- Minimum latency is 4 cycles per instruction (imem_rdy=1 in the first FETCH cycle). Each wait cycle adds 1.
- Opcodes:
  - 00000 HALT
  - 00001 NOP
  - 01000 ADDI: rd=IR[7:5], rs + sext(IR[4:0])
  - 01001 SUBI: sext(imm5) - rs
  - 11011 R-type: rd=IR[4:2]. Function IR[1:0]: 00 ADD, 01 SUB (rt-rs), 10 XOR, 11 ANDN (rs & ~rt).
  - 01100 BEQZ: taken if rs==0
  - 01101 BNEZ: taken if rs!=0
  - 00100 J: disp = sext(IR[10:0])
- Arithmetic:
  - Immediates are sign-extended to DATA_W; results wrap modulo 2^DATA_W.
  - No flags and no overflow trap.
- Next PC:
  - Default: PC+2.
  - Taken branch: PC+2+sext(IR[7:0]).
  - J: PC+2+sext(IR[10:0]).
  - All PC arithmetic is modulo 2^IMEM_AW.
  - Bit 0 of any computed target is forced to 0.
- Register 0 is a general register; it is not hardwired to zero.
- A write to rd in WB is visible to the next instruction's DECODE.
- imem_rdy while imem_req=0 is ignored.
- rst asserted mid-FETCH drops imem_req immediately. After release, fetch restarts from RESET_PC; the partially fetched word is discarded.

Optional Feature:
- Macro PROC_MC_PERF_CNT_EN.
- Defined:
  - perf_cycles increments every cycle while state is not HALTED/ERR.
  - perf_instret increments on every retire.
  - Both are 32-bit, wrap at 2^32, and freeze in HALTED/ERR.
- Undefined: both ports are constant 0 and no counter flops are synthesised.

Decomposition:
- Package proc_mc_pkg holds:
  - opcode and function localparams;
  - state encoding (FETCH, DECODE, EXEC, WB, HALTED, ERR).
- One sub-module, proc_mc_regfile: 8 x DATA_W, two async read ports, one sync write port, async reset to 0.
- ALU, decode and FSM live in proc_multicycle.

Test Plan:
- ADDI r1,r0,5 then ADDI r1,r1,-3, zero-wait memory:
  - r1=2;
  - retire pulses at cycles 4 and 8 after reset release;
  - pc_dbg ends at 4.
- R-type with r2=0x00F0, r3=0x0FF0:
  - XOR writes 0x0F00;
  - ANDN writes 0x0000 (0x00F0 & ~0x0FF0).
- BEQZ r0,+4 at PC 0x10 with r0=0: next fetch address 0x16.
  - Same with r0=1: next fetch address 0x12.
  - BNEZ takes the inverse branch.
- Memory inserting 3 wait cycles:
  - imem_addr stable throughout;
  - instruction takes 7 cycles;
  - rst pulsed mid-wait gives imem_req=0 immediately and refetch from RESET_PC.
- Illegal opcode 11111 at PC 0x2:
  - err=1 two cycles after fetch completes;
  - imem_req stays 0;
  - no retire pulse.
- HALT after 3 instructions:
  - halted=1 and the PC freezes.
  - With PROC_MC_PERF_CNT_EN (zero-wait memory): perf_instret=4, perf_cycles=16, both frozen thereafter.
